// File: rtl/cpu_sram_axi_bridge.sv
// Merges the core's inst/data SRAM-like ports onto one AXI3 master, with a single outstanding transaction per port.
// addr_ok is combinational on accept. AR/AW/W are held until ready. rready is always high and bready is held off when a data read returns in the same cycle.
module cpu_sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_req_t;

  ar_state_t ar_state;
  w_state_t  w_state;
  wr_req_t   wr_q;
  logic      inst_busy, data_busy;

  logic inst_rd_cand, data_rd_cand;
  logic inst_rd_acc, data_rd_acc, data_wr_acc;
  logic inst_ret, data_rd_ret, wr_done;
  logic rid_is_data;

  assign rid_is_data  = rvalid && (rid == DATA_ID);
  assign inst_rd_cand = resetn && inst_sram_req && !inst_busy;
  assign data_rd_cand = resetn && data_sram_req && !data_sram_wr && !data_busy;
  // Data reads take priority over instruction fetches on the shared AR channel.
  assign data_rd_acc  = (ar_state == AR_IDLE) && data_rd_cand;
  assign inst_rd_acc  = (ar_state == AR_IDLE) && inst_rd_cand && !data_rd_cand;
  assign data_wr_acc  = resetn && (w_state == W_IDLE) && data_sram_req && data_sram_wr && !data_busy;

  assign inst_ret    = resetn && rvalid && (rid == INST_ID) && inst_busy;
  // A data-id R beat only completes a read when no write owns the data port.
  assign data_rd_ret = resetn && rid_is_data && data_busy && (w_state == W_IDLE);
  assign bready      = resetn && (w_state == W_RESP) && !rid_is_data;
  assign wr_done     = bvalid && bready;
  assign rready      = resetn;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = inst_ret;
  assign data_sram_data_ok = data_rd_ret || wr_done;
  assign inst_sram_rdata   = inst_ret ? rdata : 32'd0;
  assign data_sram_rdata   = data_rd_ret ? rdata : 32'd0;

  assign arvalid = (ar_state == AR_SEND);
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = wr_q.addr;
  assign awsize  = wr_q.size;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = DATA_ID;
  assign wdata   = wr_q.data;
  assign wstrb   = wr_q.strb;
  assign wlast   = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_state  <= AR_IDLE;
      w_state   <= W_IDLE;
      arid      <= 4'd0;
      araddr    <= 32'd0;
      arsize    <= 3'd0;
      wr_q      <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (data_rd_acc) begin
            arid     <= DATA_ID;
            araddr   <= data_sram_addr;
            arsize   <= {1'b0, data_sram_size};
            ar_state <= AR_SEND;
          end else if (inst_rd_acc) begin
            arid     <= INST_ID;
            araddr   <= inst_sram_addr;
            arsize   <= {1'b0, inst_sram_size};
            ar_state <= AR_SEND;
          end
        end
        AR_SEND: if (arready) ar_state <= AR_IDLE;
        default: ar_state <= AR_IDLE;
      endcase

      case (w_state)
        W_IDLE: begin
          if (data_wr_acc) begin
            wr_q    <= '{addr: data_sram_addr, size: {1'b0, data_sram_size},
                         strb: data_sram_wstrb, data: data_sram_wdata};
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            w_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // AW and W may complete in either order; move on once neither is still pending.
          if ((!awvalid || awready) && (!wvalid || wready)) w_state <= W_RESP;
        end
        W_RESP:  if (wr_done) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase

      if (inst_rd_acc)   inst_busy <= 1'b1;
      else if (inst_ret) inst_busy <= 1'b0;

      if (data_rd_acc || data_wr_acc)  data_busy <= 1'b1;
      else if (data_rd_ret || wr_done) data_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// Bench for cpu_sram_axi_bridge: scripted scenarios followed by randomized CPU traffic against a memory-backed AXI responder.
module tb_cpu_sram_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0]  inst_sram_wstrb;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  cpu_sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  always @(posedge clk) begin
    if (resetn) begin
      if (arvalid && arready) ar_cnt++;
      if (awvalid && awready) aw_cnt++;
      if (wvalid && wready)   w_cnt++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_all();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; awready = 0; wready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    bid = 4'd1; bresp = 0; bvalid = 0;
  endtask

  // Reference model: CPU-side view of outstanding ops plus a small memory.
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdat;
  } op_t;
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } rd_t;

  localparam logic [31:0] DBASE = 32'h0000_1000;

  op_t         ireq, dreq, ip, dp;
  bit          ireq_on, dreq_on, ipend, dpend, allow_new;
  rd_t         rq[$];
  int          rsel;
  logic [31:0] fmem[16];
  logic [31:0] shadow[16];
  bit          aw_seen, w_seen, b_owed;
  logic [31:0] aw_addr_s, w_dat_s;
  logic [3:0]  w_strb_s;

  function automatic logic [31:0] rom_val(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [3:0] widx(input logic [31:0] a);
    return a[5:2];
  endfunction

  function automatic logic [31:0] fab_read(input logic [31:0] a);
    if ((a & 32'hFFFF_FFC0) == DBASE) return fmem[widx(a)];
    return rom_val(a);
  endfunction

  task automatic rnd_cycle();
    nxt();
    if (!ireq_on && allow_new && $urandom_range(0, 2) == 0) begin
      ireq_on   = 1;
      ireq.wr   = 0;
      ireq.size = 2'd2;
      ireq.addr = 32'h1FC0_0000 + 32'($urandom_range(0, 255)) * 4;
    end
    inst_sram_req   = ireq_on;
    inst_sram_addr  = ireq.addr;
    inst_sram_size  = ireq.size;
    inst_sram_wr    = 1'($urandom_range(0, 1));
    inst_sram_wstrb = 4'($urandom);
    inst_sram_wdata = $urandom;
    if (!dreq_on && allow_new && $urandom_range(0, 2) == 0) begin
      dreq_on   = 1;
      dreq.wr   = 1'($urandom_range(0, 1));
      dreq.size = 2'($urandom_range(0, 2));
      dreq.addr = DBASE + 32'($urandom_range(0, 15)) * 4;
      dreq.strb = 4'($urandom_range(1, 15));
      dreq.wdat = $urandom;
    end
    data_sram_req   = dreq_on;
    data_sram_wr    = dreq.wr;
    data_sram_size  = dreq.size;
    data_sram_addr  = dreq.addr;
    data_sram_wstrb = dreq.strb;
    data_sram_wdata = dreq.wdat;

    arready = 1'($urandom_range(0, 1));
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
    if (rq.size() > 0 && $urandom_range(0, 1) == 1) begin
      rsel   = $urandom_range(0, rq.size() - 1);
      rvalid = 1;
      rid    = rq[rsel].id;
      rdata  = fab_read(rq[rsel].addr);
    end else begin
      rvalid = 0;
      rid    = 4'($urandom);
      rdata  = $urandom;
    end
    bvalid = b_owed && (bvalid || $urandom_range(0, 1) == 1);

    smp();
    if (inst_sram_addr_ok) begin
      check("i_aok_req", ireq_on, 1);
      check("i_one_outstanding", ipend, 0);
      ipend = 1; ip = ireq; ireq_on = 0;
    end
    if (data_sram_addr_ok) begin
      check("d_aok_req", dreq_on, 1);
      check("d_one_outstanding", dpend, 0);
      dpend = 1; dp = dreq; dreq_on = 0;
    end
    if (inst_sram_data_ok) begin
      check("i_dok_pending", ipend, 1);
      check("i_rdata", inst_sram_rdata, rom_val(ip.addr));
      ipend = 0;
    end
    if (data_sram_data_ok) begin
      check("d_dok_pending", dpend, 1);
      if (dp.wr) shadow[widx(dp.addr)] = merge(shadow[widx(dp.addr)], dp.wdat, dp.strb);
      else       check("d_rdata", data_sram_rdata, shadow[widx(dp.addr)]);
      dpend = 0;
    end
    if (arvalid && arready) begin
      check("arlen", arlen, 0);
      check("arburst", arburst, 1);
      if (arid == 4'd0) begin
        check("i_araddr", araddr, ip.addr);
        check("i_arsize", arsize, {1'b0, ip.size});
      end else begin
        check("d_arid", arid, 1);
        check("d_ar_is_read", dp.wr, 0);
        check("d_araddr", araddr, dp.addr);
        check("d_arsize", arsize, {1'b0, dp.size});
      end
      rq.push_back('{id: arid, addr: araddr});
    end
    if (awvalid && awready) begin
      check("aw_single", aw_seen, 0);
      check("awaddr", awaddr, dp.addr);
      check("awsize", awsize, {1'b0, dp.size});
      check("awid", awid, 1);
      aw_seen = 1; aw_addr_s = awaddr;
    end
    if (wvalid && wready) begin
      check("w_single", w_seen, 0);
      check("wdata", wdata, dp.wdat);
      check("wstrb", wstrb, dp.strb);
      check("wlast", wlast, 1);
      w_seen = 1; w_dat_s = wdata; w_strb_s = wstrb;
    end
    if (aw_seen && w_seen && !b_owed) begin
      fmem[widx(aw_addr_s)] = merge(fmem[widx(aw_addr_s)], w_dat_s, w_strb_s);
      b_owed = 1;
    end
    if (rvalid) begin
      check("rready", rready, 1);
      rq.delete(rsel);
    end
    if (bvalid && bready) begin
      b_owed = 0; aw_seen = 0; w_seen = 0;
    end
  endtask

  initial begin
    int a0, aw0, w0;
    idle_all();
    resetn = 0;

    // Reset holds everything quiet even with requests and an R beat presented.
    nxt(); nxt();
    inst_sram_req = 1; data_sram_req = 1; rvalid = 1; rid = 0;
    smp();
    check("rst_i_aok", inst_sram_addr_ok, 0);
    check("rst_d_aok", data_sram_addr_ok, 0);
    check("rst_i_dok", inst_sram_data_ok, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
    check("rst_araddr", araddr, 0);
    nxt(); resetn = 1; idle_all();

    // Single instruction fetch.
    nxt(); inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2; arready = 1;
    smp(); check("t1_aok", inst_sram_addr_ok, 1); check("t1_arvalid_c0", arvalid, 0);
    nxt(); inst_sram_req = 0;
    smp(); check("t1_arvalid_c1", arvalid, 1); check("t1_araddr", araddr, 32'hBFC0_0000);
    check("t1_arid", arid, 0); check("t1_arsize", arsize, 2); check("t1_arlen", arlen, 0); check("t1_arburst", arburst, 1);
    nxt(); inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0004;
    smp(); check("t1_busy_blocks", inst_sram_addr_ok, 0); check("t1_ar_done", arvalid, 0);
    nxt(); rvalid = 1; rid = 0; rdata = 32'h3C1D_BFC0;
    smp(); check("t1_dok", inst_sram_data_ok, 1); check("t1_rdata", inst_sram_rdata, 32'h3C1D_BFC0);
    check("t1_no_accept_on_return", inst_sram_addr_ok, 0); check("t1_data_port_quiet", data_sram_data_ok, 0);
    nxt(); rvalid = 0;
    smp(); check("t1_reaccept", inst_sram_addr_ok, 1);
    nxt(); inst_sram_req = 0;
    smp(); check("t1_ar2_addr", araddr, 32'hBFC0_0004);
    nxt(); rvalid = 1; rid = 0; rdata = 32'h0000_0001;
    smp(); check("t1_dok2", inst_sram_data_ok, 1);
    nxt(); rvalid = 0; arready = 0;

    // Simultaneous inst and data reads: data first.
    a0 = ar_cnt;
    inst_sram_req = 1; inst_sram_addr = 32'h1FC0_0100; inst_sram_size = 2;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_2000; data_sram_size = 2;
    smp(); check("t2_d_aok", data_sram_addr_ok, 1); check("t2_i_wait", inst_sram_addr_ok, 0);
    nxt(); data_sram_req = 0;
    smp(); check("t2_arid_d", arid, 1); check("t2_araddr_d", araddr, 32'h0000_2000); check("t2_i_wait_send", inst_sram_addr_ok, 0);
    nxt(); arready = 1;
    smp(); check("t2_i_wait_hs", inst_sram_addr_ok, 0);
    nxt(); arready = 0;
    smp(); check("t2_ar_idle", arvalid, 0); check("t2_i_aok", inst_sram_addr_ok, 1);
    nxt(); inst_sram_req = 0; arready = 1;
    smp(); check("t2_arid_i", arid, 0); check("t2_araddr_i", araddr, 32'h1FC0_0100);
    nxt(); arready = 0;
    smp(); check("t2_ar_count", ar_cnt - a0, 2);

    // Out-of-order returns, plus a data accept alongside an inst return.
    nxt(); rvalid = 1; rid = 1; rdata = 32'hDA7A_0001;
    smp(); check("t3_d_dok", data_sram_data_ok, 1); check("t3_d_rdata", data_sram_rdata, 32'hDA7A_0001);
    check("t3_i_quiet", inst_sram_data_ok, 0);
    nxt(); rid = 0; rdata = 32'h1A57_0002;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_2004;
    smp(); check("t3_i_dok", inst_sram_data_ok, 1); check("t3_i_rdata", inst_sram_rdata, 32'h1A57_0002);
    check("t3_d_quiet", data_sram_data_ok, 0); check("t3_d_aok_with_i_ret", data_sram_addr_ok, 1);
    nxt(); rvalid = 0; data_sram_req = 0; arready = 1;
    smp(); check("t3_arid", arid, 1);
    nxt(); arready = 0; rvalid = 1; rid = 1; rdata = 32'hDA7A_0003;
    smp(); check("t3_d_dok2", data_sram_data_ok, 1); check("t3_d_rdata2", data_sram_rdata, 32'hDA7A_0003);
    nxt(); rvalid = 0;

    // Write with AW accepted three cycles before W.
    aw0 = aw_cnt; w0 = w_cnt;
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 1; data_sram_addr = 32'h1FAF_0000;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234_5678;
    smp(); check("t4_aok", data_sram_addr_ok, 1);
    nxt(); data_sram_req = 0; awready = 1;
    smp(); check("t4_valids", {awvalid, wvalid}, 2'b11); check("t4_awsize", awsize, 1);
    check("t4_awaddr", awaddr, 32'h1FAF_0000); check("t4_wstrb", wstrb, 3); check("t4_wdata", wdata, 32'h1234_5678);
    check("t4_wlast", wlast, 1); check("t4_awlen", awlen, 0);
    nxt(); awready = 0;
    smp(); check("t4_aw_dropped", awvalid, 0); check("t4_w_held", wvalid, 1); check("t4_no_bready", bready, 0);
    nxt();
    nxt(); wready = 1;
    smp(); check("t4_w_held2", wvalid, 1);
    nxt(); wready = 0;
    smp(); check("t4_w_dropped", wvalid, 0); check("t4_bready", bready, 1); check("t4_no_early_dok", data_sram_data_ok, 0);
    nxt(); bvalid = 1;
    smp(); check("t4_dok", data_sram_data_ok, 1);
    nxt(); bvalid = 0;
    smp(); check("t4_dok_once", data_sram_data_ok, 0);
    check("t4_aw_count", aw_cnt - aw0, 1); check("t4_w_count", w_cnt - w0, 1);

    // B collides with a data-id R beat.
    nxt(); data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2; data_sram_addr = 32'h1FAF_0004;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'hCAFE_F00D; awready = 1; wready = 1;
    smp(); check("t5_aok", data_sram_addr_ok, 1);
    nxt(); data_sram_req = 0;
    smp(); check("t5_valids", {awvalid, wvalid}, 2'b11);
    nxt(); awready = 0; wready = 0; bvalid = 1; rvalid = 1; rid = 1; rdata = 32'h5555_5555;
    smp(); check("t5_bready_blocked", bready, 0);
    nxt(); rvalid = 0;
    smp(); check("t5_bready", bready, 1); check("t5_wr_dok", data_sram_data_ok, 1);
    nxt(); bvalid = 0;
    smp(); check("t5_dok_once", data_sram_data_ok, 0);

    // Reset while AR and AW/W are pending.
    nxt(); inst_sram_req = 1; inst_sram_addr = 32'h1FC0_0200; inst_sram_size = 2;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1FAF_0008; data_sram_wstrb = 4'hF; data_sram_wdata = 1;
    smp(); check("t6_both_aok", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b11);
    nxt(); inst_sram_req = 0; data_sram_req = 0;
    smp(); check("t6_pending", {arvalid, awvalid, wvalid}, 3'b111);
    nxt(); resetn = 0;
    nxt(); resetn = 1; inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0010;
    smp(); check("t6_valids_cleared", {arvalid, awvalid, wvalid, bready}, 0);
    check("t6_fields_cleared", {araddr, awaddr}, 0); check("t6_new_aok", inst_sram_addr_ok, 1);
    nxt(); inst_sram_req = 0; arready = 1;
    smp(); check("t6_araddr", araddr, 32'hBFC0_0010);
    nxt(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h0000_0077;
    smp(); check("t6_dok", inst_sram_data_ok, 1); check("t6_rdata", inst_sram_rdata, 32'h0000_0077);
    nxt(); idle_all();

    // Randomized traffic.
    for (int i = 0; i < 16; i++) begin
      fmem[i]   = 32'hD000_0000 | 32'(i);
      shadow[i] = 32'hD000_0000 | 32'(i);
    end
    ireq_on = 0; dreq_on = 0; ipend = 0; dpend = 0; aw_seen = 0; w_seen = 0; b_owed = 0;
    rq.delete();
    allow_new = 1;
    for (int c = 0; c < 3000; c++) rnd_cycle();
    allow_new = 0;
    for (int c = 0; c < 500; c++) begin
      if (!(ipend || dpend || ireq_on || dreq_on || b_owed)) break;
      rnd_cycle();
    end
    check("drain_idle", {ipend, dpend, ireq_on, dreq_on, b_owed}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
